// File: rtl/posix_time_pkg.sv
// Shared constants, FSM state type and calendar helpers for the POSIX time blocks.
package posix_time_pkg;

   localparam int unsigned SEC_PER_MIN  = 60;
   localparam int unsigned SEC_PER_HOUR = 3600;
   localparam int unsigned SEC_PER_DAY  = 86400;
   localparam int unsigned EPOCH_YEAR   = 1970;

   typedef enum logic [2:0] {
      StIdle,
      StYears,
      StMonths,
      StSum,
      StDone
   } state_e;

   // Entry 0 is January; the February leap day is added by month_days().
   localparam logic [11:0][4:0] MONTH_LEN = {
      5'd31, 5'd30, 5'd31, 5'd30, 5'd31, 5'd31,
      5'd30, 5'd31, 5'd30, 5'd31, 5'd28, 5'd31
   };

   function automatic logic is_leap(input logic [11:0] year);
      return (year[1:0] == 2'b00) &&
             ((year % 12'd100 != 12'd0) || (year % 12'd400 == 12'd0));
   endfunction

   function automatic logic [4:0] month_days(input logic [3:0] month, input logic leap);
      logic [4:0] len;
      logic [3:0] idx;
      len = 5'd0;
      idx = month - 4'd1;
      if (month >= 4'd1 && month <= 4'd12) begin
         len = MONTH_LEN[idx];
         if (month == 4'd2 && leap) len = 5'd29;
      end
      return len;
   endfunction

endpackage

// File: rtl/date_time_to_posix_if.sv
// Request/result bundle of the date-time to POSIX converter.
interface date_time_to_posix_if;

   logic        start_i;
   logic [11:0] year_i;
   logic [3:0]  month_i;
   logic [4:0]  day_i;
   logic [4:0]  hour_i;
   logic [5:0]  min_i;
   logic [5:0]  sec_i;
   logic        busy_o;
   logic [31:0] posix_time_o;
   logic        valid_o;
   logic        err_o;

   modport master (
      output start_i, year_i, month_i, day_i, hour_i, min_i, sec_i,
      input  busy_o, posix_time_o, valid_o, err_o
   );

   modport slave (
      input  start_i, year_i, month_i, day_i, hour_i, min_i, sec_i,
      output busy_o, posix_time_o, valid_o, err_o
   );

endinterface

// File: rtl/days_before_date.sv
// Day count since the epoch: one year per add_year step, one month per add_month step.
module days_before_date
   import posix_time_pkg::*;
#(
   parameter int unsigned MIN_YEAR = EPOCH_YEAR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        add_year,
   input  logic        add_month,
   input  logic [11:0] year,
   input  logic [3:0]  month,
   input  logic [4:0]  day,
   output logic [15:0] days,
   output logic        last_year,
   output logic        last_month,
   output logic        months_pending
);

   logic [11:0] tgt_year_q, tgt_year_d, cur_year_q, cur_year_d;
   logic [3:0]  tgt_month_q, tgt_month_d, cur_month_q, cur_month_d;
   logic [15:0] days_q, days_d;

   always_comb begin
      tgt_year_d  = tgt_year_q;
      tgt_month_d = tgt_month_q;
      cur_year_d  = cur_year_q;
      cur_month_d = cur_month_q;
      days_d      = days_q;
      if (load) begin
         tgt_year_d  = year;
         tgt_month_d = month;
         cur_year_d  = 12'(MIN_YEAR);
         cur_month_d = 4'd1;
         days_d      = 16'(day) - 16'd1;
      end else if (add_year) begin
         days_d     = days_q + (is_leap(cur_year_q) ? 16'd366 : 16'd365);
         cur_year_d = cur_year_q + 12'd1;
      end else if (add_month) begin
         // February length depends on the target year, not the running year.
         days_d      = days_q + 16'(month_days(cur_month_q, is_leap(tgt_year_q)));
         cur_month_d = cur_month_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tgt_year_q  <= '0;
         tgt_month_q <= '0;
         cur_year_q  <= '0;
         cur_month_q <= '0;
         days_q      <= '0;
      end else begin
         tgt_year_q  <= tgt_year_d;
         tgt_month_q <= tgt_month_d;
         cur_year_q  <= cur_year_d;
         cur_month_q <= cur_month_d;
         days_q      <= days_d;
      end
   end

   assign days           = days_q;
   assign last_year      = (cur_year_q + 12'd1) >= tgt_year_q;
   assign last_month     = (cur_month_q + 4'd1) >= tgt_month_q;
   assign months_pending = cur_month_q < tgt_month_q;

endmodule

// File: rtl/date_time_to_posix.sv
// Local calendar date/time to UTC POSIX seconds, sequential day accumulation.
// Optional input validation: define DATE_TIME_TO_POSIX_RANGE_CHECK_EN.
module date_time_to_posix
   import posix_time_pkg::*;
#(
   parameter int          GMT      = 3,
   parameter int unsigned MIN_YEAR = EPOCH_YEAR,
   parameter int unsigned MAX_YEAR = 2105
) (
   input logic                 clk_i,
   input logic                 rst_n_i,
   date_time_to_posix_if.slave bus
);

   localparam logic [11:0] MinYear   = 12'(MIN_YEAR);
   localparam logic [31:0] GmtOffset = 32'(GMT * int'(SEC_PER_HOUR));

   state_e      state_q, state_d;
   logic [4:0]  hour_q, hour_d;
   logic [5:0]  min_q, min_d, sec_q, sec_d;
   logic [31:0] sum_q, sum_d, posix_q, posix_d;
   logic        valid_q, valid_d;
   logic        load, add_year, add_month;
   logic        last_year, last_month, months_pending;
   logic [15:0] days;
   logic        fields_ok;

`ifdef DATE_TIME_TO_POSIX_RANGE_CHECK_EN
   localparam logic [11:0] MaxYear = 12'(MAX_YEAR);
   logic err_q, err_d;

   always_comb begin
      fields_ok = (bus.year_i >= MinYear) && (bus.year_i <= MaxYear) &&
                  (bus.month_i >= 4'd1) && (bus.month_i <= 4'd12) &&
                  (bus.day_i >= 5'd1) &&
                  (bus.day_i <= month_days(bus.month_i, is_leap(bus.year_i))) &&
                  (bus.hour_i <= 5'd23) && (bus.min_i <= 6'd59) && (bus.sec_i <= 6'd59);
      err_d = bus.start_i && (state_q == StIdle) && !fields_ok;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) err_q <= 1'b0;
      else          err_q <= err_d;
   end

   assign bus.err_o = err_q;
`else
   logic unused_cfg;
   assign unused_cfg = ^(12'(MAX_YEAR));
   assign fields_ok  = 1'b1;
   assign bus.err_o  = 1'b0;
`endif

   days_before_date #(
      .MIN_YEAR(MIN_YEAR)
   ) u_days (
      .clk           (clk_i),
      .rst_n         (rst_n_i),
      .load          (load),
      .add_year      (add_year),
      .add_month     (add_month),
      .year          (bus.year_i),
      .month         (bus.month_i),
      .day           (bus.day_i),
      .days          (days),
      .last_year     (last_year),
      .last_month    (last_month),
      .months_pending(months_pending)
   );

   always_comb begin
      state_d   = state_q;
      hour_d    = hour_q;
      min_d     = min_q;
      sec_d     = sec_q;
      sum_d     = sum_q;
      posix_d   = posix_q;
      valid_d   = 1'b0;
      load      = 1'b0;
      add_year  = 1'b0;
      add_month = 1'b0;
      case (state_q)
         StIdle: begin
            if (bus.start_i && fields_ok) begin
               load   = 1'b1;
               hour_d = bus.hour_i;
               min_d  = bus.min_i;
               sec_d  = bus.sec_i;
               // Empty YEARS/MONTHS phases are skipped so they cost no cycles.
               if (bus.year_i > MinYear)     state_d = StYears;
               else if (bus.month_i > 4'd1)  state_d = StMonths;
               else                          state_d = StSum;
            end
         end
         StYears: begin
            add_year = 1'b1;
            if (last_year) state_d = months_pending ? StMonths : StSum;
         end
         StMonths: begin
            add_month = 1'b1;
            if (last_month) state_d = StSum;
         end
         StSum: begin
            sum_d = 32'(days) * SEC_PER_DAY + 32'(hour_q) * SEC_PER_HOUR +
                    32'(min_q) * SEC_PER_MIN + 32'(sec_q) - GmtOffset;
            state_d = StDone;
         end
         StDone: begin
            posix_d = sum_q;
            valid_d = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= StIdle;
         hour_q  <= '0;
         min_q   <= '0;
         sec_q   <= '0;
         sum_q   <= '0;
         posix_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hour_q  <= hour_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         sum_q   <= sum_d;
         posix_q <= posix_d;
         valid_q <= valid_d;
      end
   end

   assign bus.busy_o       = (state_q != StIdle);
   assign bus.posix_time_o = posix_q;
   assign bus.valid_o      = valid_q;

endmodule

// File: tb/tb_date_time_to_posix.sv
// Self-checking bench: GMT=0 and GMT=3 converters against a calendar reference model.
module tb_date_time_to_posix;

   localparam longint Two32 = 64'sh1_0000_0000;

   logic   clk   = 1'b0;
   logic   rst_n = 1'b0;
   int     tests = 0;
   int     fails = 0;
   longint last0 = 0;
   longint last3 = 0;

   always #5 clk = ~clk;

   date_time_to_posix_if bus0 ();
   date_time_to_posix_if bus3 ();

   date_time_to_posix #(.GMT(0), .MIN_YEAR(1970), .MAX_YEAR(2105)) dut0 (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .bus    (bus0.slave)
   );

   date_time_to_posix #(.GMT(3), .MIN_YEAR(1970), .MAX_YEAR(2105)) dut3 (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .bus    (bus3.slave)
   );

   function automatic bit tb_leap(input int y);
      return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
   endfunction

   function automatic int tb_mlen(input int y, input int m);
      int len[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
      return len[m-1] + ((m == 2 && tb_leap(y)) ? 1 : 0);
   endfunction

   function automatic longint model(input int y, input int m, input int d, input int h,
                                    input int mi, input int s, input int g);
      longint days, v;
      days = d - 1;
      for (int yy = 1970; yy < y; yy++) days += tb_leap(yy) ? 366 : 365;
      for (int mm = 1; mm < m; mm++) days += tb_mlen(y, mm);
      v = days * 86400 + h * 3600 + mi * 60 + s - g * 3600;
      v = v % Two32;
      if (v < 0) v += Two32;
      return v;
   endfunction

   task automatic check(input string tag, input longint obs, input longint exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input int y, input int m, input int d, input int h, input int mi,
                        input int s, input logic st);
      bus0.year_i = 12'(y);  bus3.year_i = 12'(y);
      bus0.month_i = 4'(m);  bus3.month_i = 4'(m);
      bus0.day_i = 5'(d);    bus3.day_i = 5'(d);
      bus0.hour_i = 5'(h);   bus3.hour_i = 5'(h);
      bus0.min_i = 6'(mi);   bus3.min_i = 6'(mi);
      bus0.sec_i = 6'(s);    bus3.sec_i = 6'(s);
      bus0.start_i = st;     bus3.start_i = st;
   endtask

   task automatic set_start(input logic st);
      bus0.start_i = st;
      bus3.start_i = st;
   endtask

   task automatic count_pulses(input int cycles, output int nv, output longint first);
      nv    = 0;
      first = -1;
      for (int n = 0; n < cycles; n++) begin
         @(posedge clk); #1;
         if (bus0.valid_o || bus0.err_o || bus3.valid_o || bus3.err_o) begin
            if (nv == 0) first = bus0.posix_time_o;
            nv++;
         end
      end
   endtask

   task automatic run_req(input int y, input int m, input int d, input int h, input int mi,
                          input int s, input string tag, output longint r0, output longint r3);
      int     exp_lat, lat0, lat3;
      longint e0, e3;
      e0      = model(y, m, d, h, mi, s, 0);
      e3      = model(y, m, d, h, mi, s, 3);
      exp_lat = ((y > 1970) ? y - 1970 : 0) + m - 1 + 2;
      @(negedge clk);
      drive(y, m, d, h, mi, s, 1'b1);
      @(posedge clk); #1;
      set_start(1'b0);
      check({tag, "_busy"}, bus0.busy_o, 1);
      check({tag, "_err"}, bus0.err_o, 0);
      lat0 = -1; lat3 = -1; r0 = -1; r3 = -1;
      for (int n = 1; n <= 400 && (lat0 < 0 || lat3 < 0); n++) begin
         @(posedge clk); #1;
         if (lat0 < 0 && bus0.valid_o) begin
            lat0 = n;
            r0   = bus0.posix_time_o;
            check({tag, "_busy_end"}, bus0.busy_o, 0);
         end
         if (lat3 < 0 && bus3.valid_o) begin
            lat3 = n;
            r3   = bus3.posix_time_o;
         end
      end
      check({tag, "_lat0"}, lat0, exp_lat);
      check({tag, "_lat3"}, lat3, exp_lat);
      check({tag, "_gmt0"}, r0, e0);
      check({tag, "_gmt3"}, r3, e3);
      @(posedge clk); #1;
      check({tag, "_pulse"}, bus0.valid_o, 0);
      check({tag, "_held"}, bus0.posix_time_o, e0);
      last0 = e0;
      last3 = e3;
   endtask

   task automatic err_req(input int y, input int m, input int d, input string tag);
      int     nv;
      longint v;
      @(negedge clk);
      drive(y, m, d, 0, 0, 0, 1'b1);
      @(posedge clk); #1;
      set_start(1'b0);
      check({tag, "_err"}, bus0.err_o, 1);
      check({tag, "_valid"}, bus0.valid_o, 0);
      check({tag, "_busy"}, bus0.busy_o, 0);
      @(posedge clk); #1;
      check({tag, "_err_pulse"}, bus0.err_o, 0);
      count_pulses(20, nv, v);
      check({tag, "_quiet"}, nv, 0);
      check({tag, "_held"}, bus0.posix_time_o, last0);
   endtask

   initial begin
      int     nv, y, m, d;
      longint r0, r3, v, e0;

      drive(0, 0, 0, 0, 0, 0, 1'b0);
      #1;
      check("rst_posix", bus0.posix_time_o, 0);
      check("rst_busy", bus0.busy_o, 0);
      check("rst_valid", bus0.valid_o, 0);
      check("rst_err", bus0.err_o, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      run_req(1970, 1, 1, 0, 0, 0, "epoch", r0, r3);
      check("epoch_zero", r0, 0);
      check("epoch_wrap", r3, 64'd4294956496);
      run_req(1970, 1, 1, 3, 0, 0, "gmt3", r0, r3);
      check("gmt3_zero", r3, 0);
      run_req(2000, 3, 1, 0, 0, 0, "y2k", r0, r3);
      check("y2k_const", r0, 951868800);
      run_req(2038, 1, 19, 3, 14, 7, "y2038", r0, r3);
      check("y2038_const", r0, 2147483647);
      run_req(2100, 3, 1, 23, 59, 59, "y2100", r0, r3);
      run_req(2105, 12, 31, 23, 59, 59, "max", r0, r3);

      for (int i = 0; i < 8; i++) begin
         y = $urandom_range(2105, 1970);
         m = $urandom_range(12, 1);
         d = $urandom_range(tb_mlen(y, m), 1);
         run_req(y, m, d, $urandom_range(23, 0), $urandom_range(59, 0), $urandom_range(59, 0),
                 "rand", r0, r3);
      end

      // Second request two edges after the first must be dropped.
      e0 = model(1975, 6, 10, 12, 0, 0, 0);
      @(negedge clk);
      drive(1975, 6, 10, 12, 0, 0, 1'b1);
      @(posedge clk); #1;
      set_start(1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(1970, 1, 1, 0, 0, 0, 1'b1);
      @(posedge clk); #1;
      set_start(1'b0);
      count_pulses(60, nv, v);
      check("overlap_count", nv, 1);
      check("overlap_value", v, e0);
      last0 = e0;

      // Start during the DONE cycle must be dropped.
      e0 = model(1971, 2, 1, 1, 2, 3, 0);
      @(negedge clk);
      drive(1971, 2, 1, 1, 2, 3, 1'b1);
      @(posedge clk); #1;
      set_start(1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      drive(1980, 7, 4, 0, 0, 0, 1'b1);
      @(posedge clk); #1;
      set_start(1'b0);
      check("done_valid", bus0.valid_o, 1);
      check("done_value", bus0.posix_time_o, e0);
      count_pulses(40, nv, v);
      check("done_drop", nv, 0);
      check("done_busy", bus0.busy_o, 0);
      last0 = e0;

      // Reset in the middle of the YEARS phase aborts silently.
      @(negedge clk);
      drive(2024, 5, 5, 10, 0, 0, 1'b1);
      @(posedge clk); #1;
      set_start(1'b0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_posix0", bus0.posix_time_o, 0);
      check("abort_posix3", bus3.posix_time_o, 0);
      check("abort_busy", bus0.busy_o, 0);
      check("abort_valid", bus0.valid_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      count_pulses(120, nv, v);
      check("abort_quiet", nv, 0);
      check("abort_held", bus0.posix_time_o, 0);
      last0 = 0;
      run_req(2024, 5, 5, 10, 0, 0, "after_abort", r0, r3);

`ifdef DATE_TIME_TO_POSIX_RANGE_CHECK_EN
      err_req(2100, 2, 29, "feb29_2100");
      err_req(2024, 13, 1, "month13");
`else
      run_req(1969, 5, 7, 8, 9, 10, "pre_epoch", r0, r3);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
